// File: rtl/cu_pkg.sv
// Shared definitions for the control unit: opcodes, ALU operation codes,
// FSM state encoding, opcode classes and small decode helpers.
package cu_pkg;

  typedef enum logic [3:0] {
    ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } cu_state_e;

  typedef enum logic [3:0] {
    CLS_ALU_R, CLS_ALU_I, CLS_LDI, CLS_LD, CLS_ST, CLS_MULDIV, CLS_NEGNOT, CLS_BR,
    CLS_JR, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT, CLS_ILL
  } cu_class_e;

  localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3,  OP_SUB  = 5'd4,  OP_AND  = 5'd5,  OP_OR   = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7,  OP_ROL  = 5'd8,  OP_SHR  = 5'd9,  OP_SHRA = 5'd10;
  localparam logic [4:0] OP_SHL  = 5'd11, OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI  = 5'd14;
  localparam logic [4:0] OP_MUL  = 5'd15, OP_DIV  = 5'd16, OP_NEG  = 5'd17, OP_NOT  = 5'd18;
  localparam logic [4:0] OP_BR   = 5'd19, OP_JR   = 5'd20, OP_IN   = 5'd22, OP_OUT  = 5'd23;
  localparam logic [4:0] OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_NOP  = 5'd26, OP_HALT = 5'd27;

  // ADD is zero so an idle/reset control word is all zeros.
  localparam logic [4:0] ALU_ADD = 5'd0,  ALU_SUB = 5'd1,  ALU_AND  = 5'd2,  ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_ROR = 5'd4,  ALU_ROL = 5'd5,  ALU_SHR  = 5'd6,  ALU_SHRA = 5'd7;
  localparam logic [4:0] ALU_SHL = 5'd8,  ALU_MUL = 5'd9,  ALU_DIV  = 5'd10, ALU_NEG = 5'd11;
  localparam logic [4:0] ALU_NOT = 5'd12;

  typedef struct packed {
    logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, write, ir_in;
    logic y_in, z_in, zlow_out, zhigh_out, gra, grb, grc, r_in, r_out, ba_out, c_out;
    logic con_in, hi_in, lo_in, hi_out, lo_out, out_port_in, in_port_out;
  } cu_strobes_t;

  function automatic logic [4:0] alu_op(input logic [4:0] opcode);
    case (opcode)
      OP_SUB:          return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR, OP_ORI:   return ALU_OR;
      OP_ROR:          return ALU_ROR;
      OP_ROL:          return ALU_ROL;
      OP_SHR:          return ALU_SHR;
      OP_SHRA:         return ALU_SHRA;
      OP_SHL:          return ALU_SHL;
      OP_MUL:          return ALU_MUL;
      OP_DIV:          return ALU_DIV;
      OP_NEG:          return ALU_NEG;
      OP_NOT:          return ALU_NOT;
      default:         return ALU_ADD;
    endcase
  endfunction

  function automatic cu_class_e op_class(input logic [4:0] opcode);
    if (opcode >= OP_ADD && opcode <= OP_SHL) return CLS_ALU_R;
    if (opcode >= OP_ADDI && opcode <= OP_ORI) return CLS_ALU_I;
    case (opcode)
      OP_LD:           return CLS_LD;
      OP_LDI:          return CLS_LDI;
      OP_ST:           return CLS_ST;
      OP_MUL, OP_DIV:  return CLS_MULDIV;
      OP_NEG, OP_NOT:  return CLS_NEGNOT;
      OP_BR:           return CLS_BR;
      OP_JR:           return CLS_JR;
      OP_IN:           return CLS_IN;
      OP_OUT:          return CLS_OUT;
      OP_MFHI:         return CLS_MFHI;
      OP_MFLO:         return CLS_MFLO;
      OP_NOP:          return CLS_NOP;
      OP_HALT:         return CLS_HALT;
      default:         return CLS_ILL;
    endcase
  endfunction

  // Final execute step of each class; the FSM returns to T0 after it.
  function automatic cu_state_e last_step(input cu_class_e cls);
    case (cls)
      CLS_ALU_R, CLS_ALU_I, CLS_LDI: return ST_T5;
      CLS_LD, CLS_ST:                return ST_T7;
      CLS_MULDIV, CLS_BR:            return ST_T6;
      CLS_NEGNOT:                    return ST_T4;
      default:                       return ST_T3;
    endcase
  endfunction

endpackage

// File: rtl/cu_step_decode.sv
// Combinational decode of FSM state and opcode into the control strobes and
// the ALU operation code. Only fetch/execute steps drive anything.
import cu_pkg::*;

module cu_step_decode (
  input  cu_state_e   state,
  input  logic [4:0]  opcode,
  input  logic        con_ff,
  output cu_strobes_t strb,
  output logic [4:0]  alu_ctrl
);

  cu_class_e cls;
  assign cls = op_class(opcode);

  // Strobe pattern per step: common fetch, then the class-specific sequence.
  always_comb begin
    strb     = '0;
    alu_ctrl = ALU_ADD;
    case (state)
      ST_T0: begin strb.pc_out = 1'b1; strb.mar_in = 1'b1; strb.inc_pc = 1'b1; end
      ST_T1: begin strb.read = 1'b1; strb.mdr_in = 1'b1; end
      ST_T2: begin strb.mdr_out = 1'b1; strb.ir_in = 1'b1; end
      default: ;
    endcase
    case (cls)
      CLS_ALU_R, CLS_ALU_I: begin
        case (state)
          ST_T3: begin strb.grb = 1'b1; strb.r_out = 1'b1; strb.y_in = 1'b1; end
          ST_T4: begin
            strb.z_in = 1'b1;
            alu_ctrl  = alu_op(opcode);
            if (cls == CLS_ALU_R) begin strb.grc = 1'b1; strb.r_out = 1'b1; end
            else strb.c_out = 1'b1;
          end
          ST_T5: begin strb.zlow_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1; end
          default: ;
        endcase
      end
      CLS_LDI, CLS_LD, CLS_ST: begin
        case (state)
          ST_T3: begin strb.grb = 1'b1; strb.ba_out = 1'b1; strb.y_in = 1'b1; end
          ST_T4: begin strb.c_out = 1'b1; strb.z_in = 1'b1; end
          ST_T5: begin
            strb.zlow_out = 1'b1;
            if (cls == CLS_LDI) begin strb.gra = 1'b1; strb.r_in = 1'b1; end
            else strb.mar_in = 1'b1;
          end
          ST_T6: begin
            strb.mdr_in = 1'b1;
            if (cls == CLS_LD) strb.read = 1'b1;
            if (cls == CLS_ST) begin strb.gra = 1'b1; strb.r_out = 1'b1; end
          end
          ST_T7: begin
            if (cls == CLS_LD) begin strb.mdr_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1; end
            if (cls == CLS_ST) strb.write = 1'b1;
          end
          default: ;
        endcase
      end
      CLS_MULDIV: begin
        case (state)
          ST_T3: begin strb.gra = 1'b1; strb.r_out = 1'b1; strb.y_in = 1'b1; end
          ST_T4: begin strb.grb = 1'b1; strb.r_out = 1'b1; strb.z_in = 1'b1; alu_ctrl = alu_op(opcode); end
          ST_T5: begin strb.zlow_out = 1'b1; strb.lo_in = 1'b1; end
          ST_T6: begin strb.zhigh_out = 1'b1; strb.hi_in = 1'b1; end
          default: ;
        endcase
      end
      CLS_NEGNOT: begin
        case (state)
          ST_T3: begin strb.grb = 1'b1; strb.r_out = 1'b1; strb.z_in = 1'b1; alu_ctrl = alu_op(opcode); end
          ST_T4: begin strb.zlow_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1; end
          default: ;
        endcase
      end
      CLS_BR: begin
        case (state)
          ST_T3: begin strb.gra = 1'b1; strb.r_out = 1'b1; strb.con_in = 1'b1; end
          ST_T4: begin strb.pc_out = 1'b1; strb.y_in = 1'b1; end
          ST_T5: begin strb.c_out = 1'b1; strb.z_in = 1'b1; end
          ST_T6: begin strb.zlow_out = 1'b1; strb.pc_in = con_ff; end
          default: ;
        endcase
      end
      CLS_JR:   if (state == ST_T3) begin strb.gra = 1'b1; strb.r_out = 1'b1; strb.pc_in = 1'b1; end
      CLS_IN:   if (state == ST_T3) begin strb.in_port_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1; end
      CLS_OUT:  if (state == ST_T3) begin strb.gra = 1'b1; strb.r_out = 1'b1; strb.out_port_in = 1'b1; end
      CLS_MFHI: if (state == ST_T3) begin strb.hi_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1; end
      CLS_MFLO: if (state == ST_T3) begin strb.lo_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU control unit: Moore FSM sequencing fetch (T0-T2) and the
// per-opcode execute steps. Build option CU_ILLEGAL_TRAP_EN: when defined,
// an illegal opcode sets the sticky illegal flag and halts; otherwise it
// behaves as nop.
//
// state | meaning
// RESET | held in / just out of clear, no strobes
// T0-T2 | instruction fetch
// T3-T7 | execute steps of the current opcode class
// HALT  | stopped until clear, no strobes
import cu_pkg::*;

module control_unit (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic        PCout, PCin, incPC,
  output logic        MARin, MDRin, MDRout, Read, Write,
  output logic        IRin, Yin, Zin, Zlowout, Zhighout,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout,
  output logic        ConIn, HIin, LOin, HIout, LOout, OutPortIn, InPortOut,
  output logic [4:0]  aluControl,
  output logic        run,
  output logic [3:0]  step,
  output logic        illegal
);

`ifdef CU_ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  cu_state_e   state_q, state_d;
  logic        illegal_q, illegal_d;
  cu_class_e   cls;
  cu_strobes_t strb;
  logic        unused_ir_bits;

  assign cls            = op_class(ir[31:27]);
  assign unused_ir_bits = ^ir[26:0];

  // Next state: fetch steps advance, T2 dispatches on the opcode class,
  // execute steps advance until the class's final step.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_RESET: state_d = ST_T0;
      ST_T0:    state_d = ST_T1;
      ST_T1:    state_d = ST_T2;
      ST_T2: begin
        case (cls)
          CLS_NOP:  state_d = ST_T0;
          CLS_HALT: state_d = ST_HALT;
          CLS_ILL: begin
            state_d   = TRAP_EN ? ST_HALT : ST_T0;
            illegal_d = illegal_q | TRAP_EN;
          end
          default:  state_d = ST_T3;
        endcase
      end
      ST_HALT:  state_d = ST_HALT;
      default: begin
        if (state_q == last_step(cls) || state_q == ST_T7) state_d = ST_T0;
        else state_d = cu_state_e'(state_q + 4'd1);
      end
    endcase
  end

  // State and sticky illegal flag; clear forces RESET at once.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= ST_RESET;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  cu_step_decode u_decode (
    .state    (state_q),
    .opcode   (ir[31:27]),
    .con_ff   (con_ff),
    .strb     (strb),
    .alu_ctrl (aluControl)
  );

  // Debug step number and run indication from the registered state.
  always_comb begin
    run = (state_q != ST_RESET) && (state_q != ST_HALT);
    case (state_q)
      ST_RESET: step = 4'd0;
      ST_HALT:  step = 4'hF;
      default:  step = 4'(state_q) - 4'd1;
    endcase
  end

  assign illegal   = illegal_q;
  assign PCout     = strb.pc_out;
  assign PCin      = strb.pc_in;
  assign incPC     = strb.inc_pc;
  assign MARin     = strb.mar_in;
  assign MDRin     = strb.mdr_in;
  assign MDRout    = strb.mdr_out;
  assign Read      = strb.read;
  assign Write     = strb.write;
  assign IRin      = strb.ir_in;
  assign Yin       = strb.y_in;
  assign Zin       = strb.z_in;
  assign Zlowout   = strb.zlow_out;
  assign Zhighout  = strb.zhigh_out;
  assign Gra       = strb.gra;
  assign Grb       = strb.grb;
  assign Grc       = strb.grc;
  assign Rin       = strb.r_in;
  assign Rout      = strb.r_out;
  assign BAout     = strb.ba_out;
  assign Cout      = strb.c_out;
  assign ConIn     = strb.con_in;
  assign HIin      = strb.hi_in;
  assign LOin      = strb.lo_in;
  assign HIout     = strb.hi_out;
  assign LOout     = strb.lo_out;
  assign OutPortIn = strb.out_port_in;
  assign InPortOut = strb.in_port_out;

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: table of instructions with per-step strobe
// masks, a scoreboard queue of expected outputs, and hand-written sequences
// for clear, halt and illegal opcodes.
import cu_pkg::*;

module tb_control_unit;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] ir = 32'h0;
  logic        con_ff = 1'b0;
  logic PCout, PCin, incPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin;
  logic Zlowout, Zhighout, Gra, Grb, Grc, Rin, Rout, BAout, Cout, ConIn;
  logic HIin, LOin, HIout, LOout, OutPortIn, InPortOut, run, illegal;
  logic [4:0] aluControl;
  logic [3:0] step;

  control_unit dut (
    .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff),
    .PCout(PCout), .PCin(PCin), .incPC(incPC),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Write(Write),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .ConIn(ConIn), .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
    .OutPortIn(OutPortIn), .InPortOut(InPortOut),
    .aluControl(aluControl), .run(run), .step(step), .illegal(illegal)
  );

  always #5 clock = ~clock;

  localparam logic [26:0] M_PCOUT = 27'h1 << 26, M_PCIN  = 27'h1 << 25, M_INCPC = 27'h1 << 24;
  localparam logic [26:0] M_MARIN = 27'h1 << 23, M_MDRIN = 27'h1 << 22, M_MDROUT = 27'h1 << 21;
  localparam logic [26:0] M_READ  = 27'h1 << 20, M_WRITE = 27'h1 << 19, M_IRIN = 27'h1 << 18;
  localparam logic [26:0] M_YIN   = 27'h1 << 17, M_ZIN   = 27'h1 << 16, M_ZLO  = 27'h1 << 15;
  localparam logic [26:0] M_ZHI   = 27'h1 << 14, M_GRA   = 27'h1 << 13, M_GRB  = 27'h1 << 12;
  localparam logic [26:0] M_GRC   = 27'h1 << 11, M_RIN   = 27'h1 << 10, M_ROUT = 27'h1 << 9;
  localparam logic [26:0] M_BAOUT = 27'h1 << 8,  M_COUT  = 27'h1 << 7,  M_CONIN = 27'h1 << 6;
  localparam logic [26:0] M_HIIN  = 27'h1 << 5,  M_LOIN  = 27'h1 << 4,  M_HIOUT = 27'h1 << 3;
  localparam logic [26:0] M_LOOUT = 27'h1 << 2,  M_OUTP  = 27'h1 << 1,  M_INP  = 27'h1 << 0;
  localparam logic [26:0] F0 = M_PCOUT | M_MARIN | M_INCPC;
  localparam logic [26:0] F1 = M_READ | M_MDRIN;
  localparam logic [26:0] F2 = M_MDROUT | M_IRIN;

  logic [26:0] obs_strb;
  assign obs_strb = {PCout, PCin, incPC, MARin, MDRin, MDRout, Read, Write, IRin,
                     Yin, Zin, Zlowout, Zhighout, Gra, Grb, Grc, Rin, Rout, BAout, Cout,
                     ConIn, HIin, LOin, HIout, LOout, OutPortIn, InPortOut};

  typedef struct packed {
    logic [4:0]        op;
    logic              con;
    logic [3:0]        n;      // number of steps T0..Tlast
    logic [2:0]        as;     // step carrying the ALU op (0 = none)
    logic [4:0]        alu;
    logic [7:0][26:0]  mask;
  } instr_t;

  typedef struct packed {
    logic [3:0]  step;
    logic [26:0] mask;
    logic [4:0]  alu;
    logic        run;
    logic        ill;
    logic        chk_step;
  } exp_t;

  instr_t tbl [18];
  exp_t   sbq [$];
  int     checks = 0;
  int     errors = 0;

  function automatic instr_t mk(input logic [4:0] op, input logic con, input logic [3:0] n,
                                input logic [2:0] as, input logic [4:0] alu,
                                input logic [26:0] m3, input logic [26:0] m4, input logic [26:0] m5,
                                input logic [26:0] m6, input logic [26:0] m7);
    instr_t r;
    r.op = op; r.con = con; r.n = n; r.as = as; r.alu = alu;
    r.mask[0] = F0; r.mask[1] = F1; r.mask[2] = F2;
    r.mask[3] = m3; r.mask[4] = m4; r.mask[5] = m5; r.mask[6] = m6; r.mask[7] = m7;
    return r;
  endfunction

  function automatic exp_t mkexp(input logic [3:0] s, input logic [26:0] m, input logic [4:0] a,
                                 input logic r, input logic il, input logic cs);
    exp_t e;
    e.step = s; e.mask = m; e.alu = a; e.run = r; e.ill = il; e.chk_step = cs;
    return e;
  endfunction

  function automatic logic [31:0] mkir(input logic [4:0] op);
    return {op, 4'd1, 4'd2, 4'd3, 15'h0};
  endfunction

  task automatic check(input string nm);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, nothing expected", nm);
    end else begin
      e = sbq.pop_front();
      if (obs_strb !== e.mask || aluControl !== e.alu || run !== e.run ||
          illegal !== e.ill || (e.chk_step && step !== e.step)) begin
        errors++;
        $display("FAIL %s: got step=%0d strb=%h alu=%0d run=%b ill=%b, want step=%0d strb=%h alu=%0d run=%b ill=%b",
                 nm, step, obs_strb, aluControl, run, illegal, e.step, e.mask, e.alu, e.run, e.ill);
      end
    end
  endtask

  task automatic push_fetch(input logic il);
    sbq.push_back(mkexp(4'd0, F0, ALU_ADD, 1'b1, il, 1'b1));
    sbq.push_back(mkexp(4'd1, F1, ALU_ADD, 1'b1, il, 1'b1));
    sbq.push_back(mkexp(4'd2, F2, ALU_ADD, 1'b1, il, 1'b1));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(5'd3,  1'b0, 4'd6, 3'd4, ALU_ADD,  M_GRB|M_ROUT|M_YIN, M_GRC|M_ROUT|M_ZIN, M_ZLO|M_GRA|M_RIN, '0, '0);
    tbl[1]  = mk(5'd4,  1'b0, 4'd6, 3'd4, ALU_SUB,  M_GRB|M_ROUT|M_YIN, M_GRC|M_ROUT|M_ZIN, M_ZLO|M_GRA|M_RIN, '0, '0);
    tbl[2]  = mk(5'd10, 1'b0, 4'd6, 3'd4, ALU_SHRA, M_GRB|M_ROUT|M_YIN, M_GRC|M_ROUT|M_ZIN, M_ZLO|M_GRA|M_RIN, '0, '0);
    tbl[3]  = mk(5'd13, 1'b0, 4'd6, 3'd4, ALU_AND,  M_GRB|M_ROUT|M_YIN, M_COUT|M_ZIN, M_ZLO|M_GRA|M_RIN, '0, '0);
    tbl[4]  = mk(5'd1,  1'b0, 4'd6, 3'd4, ALU_ADD,  M_GRB|M_BAOUT|M_YIN, M_COUT|M_ZIN, M_ZLO|M_GRA|M_RIN, '0, '0);
    tbl[5]  = mk(5'd0,  1'b0, 4'd8, 3'd4, ALU_ADD,  M_GRB|M_BAOUT|M_YIN, M_COUT|M_ZIN, M_ZLO|M_MARIN,
                 M_READ|M_MDRIN, M_MDROUT|M_GRA|M_RIN);
    tbl[6]  = mk(5'd2,  1'b0, 4'd8, 3'd4, ALU_ADD,  M_GRB|M_BAOUT|M_YIN, M_COUT|M_ZIN, M_ZLO|M_MARIN,
                 M_GRA|M_ROUT|M_MDRIN, M_WRITE);
    tbl[7]  = mk(5'd15, 1'b0, 4'd7, 3'd4, ALU_MUL,  M_GRA|M_ROUT|M_YIN, M_GRB|M_ROUT|M_ZIN, M_ZLO|M_LOIN, M_ZHI|M_HIIN, '0);
    tbl[8]  = mk(5'd16, 1'b0, 4'd7, 3'd4, ALU_DIV,  M_GRA|M_ROUT|M_YIN, M_GRB|M_ROUT|M_ZIN, M_ZLO|M_LOIN, M_ZHI|M_HIIN, '0);
    tbl[9]  = mk(5'd17, 1'b0, 4'd5, 3'd3, ALU_NEG,  M_GRB|M_ROUT|M_ZIN, M_ZLO|M_GRA|M_RIN, '0, '0, '0);
    tbl[10] = mk(5'd18, 1'b0, 4'd5, 3'd3, ALU_NOT,  M_GRB|M_ROUT|M_ZIN, M_ZLO|M_GRA|M_RIN, '0, '0, '0);
    tbl[11] = mk(5'd19, 1'b1, 4'd7, 3'd5, ALU_ADD,  M_GRA|M_ROUT|M_CONIN, M_PCOUT|M_YIN, M_COUT|M_ZIN, M_ZLO|M_PCIN, '0);
    tbl[12] = mk(5'd19, 1'b0, 4'd7, 3'd5, ALU_ADD,  M_GRA|M_ROUT|M_CONIN, M_PCOUT|M_YIN, M_COUT|M_ZIN, M_ZLO, '0);
    tbl[13] = mk(5'd20, 1'b0, 4'd4, 3'd0, ALU_ADD,  M_GRA|M_ROUT|M_PCIN, '0, '0, '0, '0);
    tbl[14] = mk(5'd22, 1'b0, 4'd4, 3'd0, ALU_ADD,  M_INP|M_GRA|M_RIN, '0, '0, '0, '0);
    tbl[15] = mk(5'd23, 1'b0, 4'd4, 3'd0, ALU_ADD,  M_GRA|M_ROUT|M_OUTP, '0, '0, '0, '0);
    tbl[16] = mk(5'd24, 1'b0, 4'd4, 3'd0, ALU_ADD,  M_HIOUT|M_GRA|M_RIN, '0, '0, '0, '0);
    tbl[17] = mk(5'd26, 1'b0, 4'd3, 3'd0, ALU_ADD,  '0, '0, '0, '0, '0);

    // Reset state while clear is held low.
    #1;
    for (int j = 0; j < 3; j++) begin
      sbq.push_back(mkexp(4'd0, '0, ALU_ADD, 1'b0, 1'b0, 1'b1));
      check($sformatf("reset_hold%0d", j));
      @(negedge clock);
    end
    clear = 1'b1;
    @(negedge clock);

    // Table: each instruction starts at a T0 negedge; ir changes only there.
    for (int i = 0; i < 18; i++) begin
      ir     = mkir(tbl[i].op);
      con_ff = tbl[i].con;
      for (int k = 0; k < int'(tbl[i].n); k++)
        sbq.push_back(mkexp(4'(k), tbl[i].mask[k],
                            (k == int'(tbl[i].as) && tbl[i].as != 3'd0) ? tbl[i].alu : ALU_ADD,
                            1'b1, 1'b0, 1'b1));
      for (int k = 0; k < int'(tbl[i].n); k++) begin
        if (k > 0) @(negedge clock);
        check($sformatf("op%0d_c%0d_T%0d", tbl[i].op, tbl[i].con, k));
      end
      @(negedge clock);
    end

    // ld interrupted by clear in T5; outputs drop immediately, T0 after release.
    ir = mkir(5'd0);
    for (int k = 0; k < 6; k++) sbq.push_back(mkexp(4'(k), tbl[5].mask[k], ALU_ADD, 1'b1, 1'b0, 1'b1));
    check("ldclr_T0");
    for (int k = 1; k < 6; k++) begin
      @(negedge clock);
      check($sformatf("ldclr_T%0d", k));
    end
    #2 clear = 1'b0;
    #1;
    sbq.push_back(mkexp(4'd0, '0, ALU_ADD, 1'b0, 1'b0, 1'b1));
    check("ldclr_async");
    for (int j = 0; j < 3; j++) begin
      @(negedge clock);
      sbq.push_back(mkexp(4'd0, '0, ALU_ADD, 1'b0, 1'b0, 1'b1));
      check($sformatf("ldclr_hold%0d", j));
    end
    clear = 1'b1;
    @(negedge clock);

    // halt: fetch, then 20 cycles stopped with no strobes.
    ir = mkir(5'd27);
    push_fetch(1'b0);
    check("halt_T0");
    @(negedge clock); check("halt_T1");
    @(negedge clock); check("halt_T2");
    for (int j = 0; j < 20; j++) begin
      @(negedge clock);
      sbq.push_back(mkexp(4'd0, '0, ALU_ADD, 1'b0, 1'b0, 1'b0));
      check($sformatf("halt_hold%0d", j));
    end
    #2 clear = 1'b0;
    #1;
    sbq.push_back(mkexp(4'd0, '0, ALU_ADD, 1'b0, 1'b0, 1'b1));
    check("halt_clear");
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);

    // Illegal opcode 30.
    ir = mkir(5'd30);
    push_fetch(1'b0);
    check("ill_T0");
    @(negedge clock); check("ill_T1");
    @(negedge clock); check("ill_T2");
`ifdef CU_ILLEGAL_TRAP_EN
    for (int j = 0; j < 3; j++) begin
      @(negedge clock);
      sbq.push_back(mkexp(4'd0, '0, ALU_ADD, 1'b0, 1'b1, 1'b0));
      check($sformatf("ill_halt%0d", j));
    end
    #2 clear = 1'b0;
    #1;
    sbq.push_back(mkexp(4'd0, '0, ALU_ADD, 1'b0, 1'b0, 1'b1));
    check("ill_clear");
    @(negedge clock);
    clear = 1'b1;
`else
    push_fetch(1'b0);
    @(negedge clock); check("ill_nop_T0");
    @(negedge clock); check("ill_nop_T1");
    @(negedge clock); check("ill_nop_T2");
`endif
    @(negedge clock);
    ir = mkir(5'd26);
    sbq.push_back(mkexp(4'd0, F0, ALU_ADD, 1'b1, 1'b0, 1'b1));
    check("final_T0");

    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, want 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
